// File: rtl/md5_ctrl_pkg.sv
// Shared definitions for the MD5 iteration sequencer: FSM states, block geometry,
// round encodings and the message-index multiplier/offset constants used by g(i).
package md5_ctrl_pkg;

    localparam int STEPS = 64;
    localparam int WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_FINAL = 2'd2
    } md5_state_e;

    typedef enum logic [1:0] {
        RND_F = 2'd0,
        RND_G = 2'd1,
        RND_H = 2'd2,
        RND_I = 2'd3
    } md5_round_e;

    // g(i) = (MUL*i + OFF) mod 16 per round; round F is the identity.
    localparam logic [3:0] G1_MUL = 4'd5;
    localparam logic [3:0] G1_OFF = 4'd1;
    localparam logic [3:0] G2_MUL = 4'd3;
    localparam logic [3:0] G2_OFF = 4'd5;
    localparam logic [3:0] G3_MUL = 4'd7;

endpackage

// File: rtl/md5_x_index.sv
// Combinational step decode: step index i -> message word index g(i), round
// function select and rotate select.
module md5_x_index
    import md5_ctrl_pkg::*;
(
    input  logic [5:0] step_i,
    output logic [3:0] x_addr_o,
    output logic [1:0] func_sel_o,
    output logic [1:0] shift_amnt_o
);

    logic [3:0] i4;

    assign i4           = step_i[3:0];
    assign func_sel_o   = step_i[5:4];
    assign shift_amnt_o = step_i[1:0];

    // 4-bit products wrap naturally, giving the mod-16 word index.
    always_comb begin
        x_addr_o = i4;
        case (md5_round_e'(step_i[5:4]))
            RND_F:   x_addr_o = i4;
            RND_G:   x_addr_o = i4 * G1_MUL + G1_OFF;
            RND_H:   x_addr_o = i4 * G2_MUL + G2_OFF;
            default: x_addr_o = i4 * G3_MUL;
        endcase
    end

endmodule

// File: rtl/md5_iter_ctrl.sv
// MD5 iteration sequencer: loads message words into the X buffers and steps the
// datapath through 64 rounds plus a chaining add. MD5_PINGPONG_EN enables a second X buffer.
module md5_iter_ctrl
    import md5_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       msg_valid,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic       WE1,
    output logic       XEN1,
    output logic       WE2,
    output logic       XEN2,
    output logic [3:0] wr_addr,
    output logic [3:0] X_addr,
    output logic       X_sel,
    output logic [5:0] T_addr,
    output logic [1:0] Func_sel,
    output logic [1:0] Shift_amnt,
    output logic       en1,
    output logic       en2,
    output logic       CV_sel,
    output logic       Load_done,
    output logic       busy,
    output logic       digest_valid,
    output md5_state_e dbg_state
);

    md5_state_e state_q, state_d;
    logic [5:0] step_q, step_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic       wsel_q, wsel_d;
    logic       rsel_q, rsel_d;
    logic [1:0] full_q, full_d;
    logic [1:0] last_q, last_d;
    logic       load_done_q, load_done_d;
    logic       digest_q, digest_d;
    logic       cv_sel_q, cv_sel_d;
    logic       accept;
    logic       in_step;

`ifdef MD5_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
    assign WE1   = accept & ~wsel_q;
    assign XEN1  = WE1 | (in_step & ~rsel_q);
    assign WE2   = accept & wsel_q;
    assign XEN2  = WE2 | (in_step & rsel_q);
    assign X_sel = rsel_q;
`else
    localparam bit PINGPONG = 1'b0;
    assign WE1   = accept;
    assign XEN1  = accept | in_step;
    assign WE2   = 1'b0;
    assign XEN2  = 1'b0;
    assign X_sel = 1'b0;
`endif

    // Handshake: a word transfers on any cycle where msg_valid && msg_ready;
    // msg_ready drops while the write buffer holds a block not yet hashed.
    assign msg_ready    = ~full_q[wsel_q];
    assign accept       = msg_valid & msg_ready;
    assign in_step      = (state_q == ST_STEP);
    assign en1          = in_step;
    assign en2          = (state_q == ST_FINAL);
    assign busy         = (state_q != ST_IDLE);
    assign T_addr       = step_q;
    assign wr_addr      = wr_addr_q;
    assign Load_done    = load_done_q;
    assign digest_valid = digest_q;
    assign CV_sel       = cv_sel_q;
    assign dbg_state    = state_q;

    md5_x_index u_x_index (
        .step_i       (step_q),
        .x_addr_o     (X_addr),
        .func_sel_o   (Func_sel),
        .shift_amnt_o (Shift_amnt)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        wr_addr_d   = wr_addr_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        full_d      = full_q;
        last_d      = last_q;
        load_done_d = 1'b0;
        digest_d    = 1'b0;
        cv_sel_d    = cv_sel_q;

        if (accept) begin
            wr_addr_d = wr_addr_q + 4'd1;
            if (wr_addr_q == 4'(WORDS - 1)) begin
                load_done_d    = 1'b1;
                full_d[wsel_q] = 1'b1;
                last_d[wsel_q] = msg_last;
                if (PINGPONG) wsel_d = ~wsel_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rsel_q]) begin
                    state_d = ST_STEP;
                    step_d  = '0;
                end
            end
            ST_STEP: begin
                if (step_q == 6'(STEPS - 1)) begin
                    state_d = ST_FINAL;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            ST_FINAL: begin
                full_d[rsel_q] = 1'b0;
                digest_d       = last_q[rsel_q];
                cv_sel_d       = ~last_q[rsel_q];
                state_d        = ST_IDLE;
                // The other buffer already holding a block lets hashing continue without a bubble.
                if (PINGPONG) begin
                    rsel_d = ~rsel_q;
                    if (full_q[~rsel_q]) state_d = ST_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            wr_addr_q   <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_q      <= '0;
            last_q      <= '0;
            load_done_q <= 1'b0;
            digest_q    <= 1'b0;
            cv_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            wr_addr_q   <= wr_addr_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            full_q      <= full_d;
            last_q      <= last_d;
            load_done_q <= load_done_d;
            digest_q    <= digest_d;
            cv_sel_q    <= cv_sel_d;
        end
    end

endmodule

// File: tb/tb_md5_iter_ctrl.sv
// Self-checking bench for md5_iter_ctrl; expected behaviour comes from block/step
// timing rules and a plain-arithmetic g(i) model. Builds with or without MD5_PINGPONG_EN.
module tb_md5_iter_ctrl;
    import md5_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       msg_valid;
    logic       msg_last;
    logic       msg_ready;
    logic       WE1, XEN1, WE2, XEN2;
    logic [3:0] wr_addr;
    logic [3:0] X_addr;
    logic       X_sel;
    logic [5:0] T_addr;
    logic [1:0] Func_sel;
    logic [1:0] Shift_amnt;
    logic       en1, en2, CV_sel, Load_done, busy, digest_valid;
    md5_state_e dbg_state;

`ifdef MD5_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int en1_cnt = 0, en2_cnt = 0, ld_cnt = 0, dv_cnt = 0;
    bit wbuf, rbuf;
    logic [3:0] exp_q[$];

    md5_iter_ctrl dut (
        .CLK(CLK), .RST(RST), .msg_valid(msg_valid), .msg_last(msg_last),
        .msg_ready(msg_ready), .WE1(WE1), .XEN1(XEN1), .WE2(WE2), .XEN2(XEN2),
        .wr_addr(wr_addr), .X_addr(X_addr), .X_sel(X_sel), .T_addr(T_addr),
        .Func_sel(Func_sel), .Shift_amnt(Shift_amnt), .en1(en1), .en2(en2),
        .CV_sel(CV_sel), .Load_done(Load_done), .busy(busy),
        .digest_valid(digest_valid), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (en1 === 1'b1) en1_cnt++;
        if (en2 === 1'b1) en2_cnt++;
        if (Load_done === 1'b1) ld_cnt++;
        if (digest_valid === 1'b1) dv_cnt++;
    end

    task automatic do_reset(input int n);
        RST = 1'b1;
        msg_valid = 1'b0;
        msg_last = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        wbuf = 1'b0;
        rbuf = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_g(input int i);
        case (i / 16)
            0:       return i % 16;
            1:       return (5 * i + 1) % 16;
            2:       return (3 * i + 5) % 16;
            default: return (7 * i) % 16;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Loads words start..start+nwords-1; if word 15 is reached, returns at the Load_done cycle.
    task automatic load_block(input int start, input int nwords, input bit last, input int gap_mode);
        int gap;
        for (int k = start; k < start + nwords; k++) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(posedge CLK); #1;
                msg_valid = 1'b0;
                msg_last = 1'($urandom_range(0, 1));
                @(negedge CLK);
                checks++; if ((wbuf ? WE2 : WE1) !== 1'b0) begin errors++; $display("FAIL load_idle_we: got %b want 0 (word %0d)", wbuf ? WE2 : WE1, k); end
                checks++; if (wr_addr !== 4'(k)) begin errors++; $display("FAIL load_idle_addr: got %0d want %0d", wr_addr, k); end
            end
            @(posedge CLK); #1;
            msg_valid = 1'b1;
            msg_last = (k == 15) ? last : 1'($urandom_range(0, 1));
            @(negedge CLK);
            checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1 (word %0d)", msg_ready, k); end
            checks++; if ((wbuf ? WE2 : WE1) !== 1'b1) begin errors++; $display("FAIL load_we: got %b want 1 (word %0d buf %0d)", wbuf ? WE2 : WE1, k, wbuf); end
            checks++; if ((wbuf ? XEN2 : XEN1) !== 1'b1) begin errors++; $display("FAIL load_xen: got %b want 1 (word %0d)", wbuf ? XEN2 : XEN1, k); end
            checks++; if (wr_addr !== 4'(k)) begin errors++; $display("FAIL load_wr_addr: got %0d want %0d", wr_addr, k); end
            checks++; if (Load_done !== 1'b0) begin errors++; $display("FAIL load_done_early: got %b want 0 (word %0d)", Load_done, k); end
        end
        if (start + nwords == 16) begin
            @(posedge CLK); #1;
            msg_valid = 1'b0;
            if (PP) wbuf = ~wbuf;
            @(negedge CLK);
            checks++; if (Load_done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", Load_done); end
            checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL load_wrap: got %0d want 0", wr_addr); end
        end
    endtask

    // Checks 64 steps, FINAL and the cycle after. at0: caller already sits on step 0.
    task automatic hash_block(input bit last, input bit chained, input bit at0);
        logic [3:0] eg;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(4'(ref_g(i)));
        for (int i = 0; i < 64; i++) begin
            if (!(at0 && i == 0)) @(negedge CLK);
            eg = exp_q.pop_front();
            checks++; if (en1 !== 1'b1 || en2 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL step_ctrl: en1/en2/busy got %b%b%b want 101 (step %0d)", en1, en2, busy, i); end
            checks++; if (T_addr !== 6'(i)) begin errors++; $display("FAIL step_t_addr: got %0d want %0d", T_addr, i); end
            checks++; if (X_addr !== eg) begin errors++; $display("FAIL step_x_addr: got %0d want %0d (step %0d)", X_addr, eg, i); end
            checks++; if (Func_sel !== 2'(i / 16)) begin errors++; $display("FAIL step_func: got %0d want %0d (step %0d)", Func_sel, i / 16, i); end
            checks++; if (Shift_amnt !== 2'(i % 4)) begin errors++; $display("FAIL step_shift: got %0d want %0d (step %0d)", Shift_amnt, i % 4, i); end
            checks++; if (X_sel !== rbuf) begin errors++; $display("FAIL step_x_sel: got %b want %b (step %0d)", X_sel, rbuf, i); end
            checks++; if ((rbuf ? XEN2 : XEN1) !== 1'b1) begin errors++; $display("FAIL step_xen: got %b want 1 (step %0d)", rbuf ? XEN2 : XEN1, i); end
            checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL step_digest: got %b want 0 (step %0d)", digest_valid, i); end
        end
        @(negedge CLK);
        checks++; if (en2 !== 1'b1 || en1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL final_ctrl: en1/en2/busy got %b%b%b want 011", en1, en2, busy); end
        if (PP) rbuf = ~rbuf;
        @(negedge CLK);
        checks++; if (digest_valid !== last) begin errors++; $display("FAIL post_digest: got %b want %b", digest_valid, last); end
        checks++; if (CV_sel !== ~last) begin errors++; $display("FAIL post_cv_sel: got %b want %b", CV_sel, ~last); end
        checks++; if (en1 !== chained || busy !== chained) begin errors++; $display("FAIL post_state: en1/busy got %b%b want %b%b", en1, busy, chained, chained); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        do_reset(3);
        @(negedge CLK);
        checks++; if ({WE1, XEN1, WE2, XEN2, wr_addr, X_addr, X_sel, T_addr, Func_sel, Shift_amnt,
                       en1, en2, CV_sel, Load_done, busy, digest_valid} !== 29'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {WE1, XEN1, WE2, XEN2, wr_addr, X_addr, X_sel,
                T_addr, Func_sel, Shift_amnt, en1, en2, CV_sel, Load_done, busy, digest_valid});
        end
        checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", msg_ready); end
    endtask

    task automatic test_single_block;
        int e1, e2, ld, dv;
        #1; e1 = en1_cnt; e2 = en2_cnt; ld = ld_cnt; dv = dv_cnt;
        load_block(0, 16, 1'b1, 0);
        hash_block(1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (en1_cnt - e1 !== 64) begin errors++; $display("FAIL single_en1_cycles: got %0d want 64", en1_cnt - e1); end
        checks++; if (en2_cnt - e2 !== 1) begin errors++; $display("FAIL single_en2_cycles: got %0d want 1", en2_cnt - e2); end
        checks++; if (ld_cnt - ld !== 1) begin errors++; $display("FAIL single_load_done_count: got %0d want 1", ld_cnt - ld); end
        checks++; if (dv_cnt - dv !== 1) begin errors++; $display("FAIL single_digest_count: got %0d want 1", dv_cnt - dv); end
    endtask

    task automatic test_toggle_valid;
        int ld;
        #1; ld = ld_cnt;
        load_block(0, 16, 1'b1, 1);
        hash_block(1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ld_cnt - ld !== 1) begin errors++; $display("FAIL toggle_load_done_count: got %0d want 1", ld_cnt - ld); end
    endtask

    task automatic test_two_block;
        load_block(0, 16, 1'b0, 2);
        hash_block(1'b0, 1'b0, 1'b0);
        load_block(0, 16, 1'b1, 2);
        hash_block(1'b1, 1'b0, 1'b0);
    endtask

`ifdef MD5_PINGPONG_EN
    task automatic test_pingpong;
        int e1;
        load_block(0, 16, 1'b0, 2);
        #1; e1 = en1_cnt;
        fork
            hash_block(1'b0, 1'b1, 1'b0);
            load_block(0, 16, 1'b1, 1);
        join
        hash_block(1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (en1_cnt - e1 !== 128) begin errors++; $display("FAIL pp_en1_cycles: got %0d want 128", en1_cnt - e1); end
    endtask
`else
    task automatic test_stall;
        load_block(0, 16, 1'b1, 0);
        fork
            hash_block(1'b1, 1'b0, 1'b0);
            begin
                @(posedge CLK); #1;
                msg_valid = 1'b1;
                msg_last = 1'b0;
                for (int c = 0; c < 65; c++) begin
                    @(negedge CLK);
                    checks++; if (msg_ready !== 1'b0 || WE1 !== 1'b0) begin errors++; $display("FAIL stall_ready: ready/we got %b%b want 00 (cycle %0d)", msg_ready, WE1, c); end
                    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL stall_wr_addr: got %0d want 0", wr_addr); end
                end
                @(negedge CLK);
                checks++; if (msg_ready !== 1'b1 || WE1 !== 1'b1) begin errors++; $display("FAIL stall_release: ready/we got %b%b want 11", msg_ready, WE1); end
            end
        join
        load_block(1, 15, 1'b1, 2);
        hash_block(1'b1, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid;
        int dv, ld;
        load_block(0, 16, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            checks++; if (T_addr !== 6'(i)) begin errors++; $display("FAIL mid_t_addr: got %0d want %0d", T_addr, i); end
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (en1 !== 1'b1 || T_addr !== 6'd30) begin errors++; $display("FAIL mid_step30: en1 %b T_addr %0d want 1/30", en1, T_addr); end
        @(posedge CLK); #1;
        RST = 1'b0;
        wbuf = 1'b0;
        rbuf = 1'b0;
        #1; dv = dv_cnt;
        @(negedge CLK);
        checks++; if ({WE1, WE2, wr_addr, T_addr, en1, en2, CV_sel, Load_done, busy, digest_valid} !== 18'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0", {WE1, WE2, wr_addr, T_addr, en1, en2, CV_sel, Load_done, busy, digest_valid});
        end
        checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", msg_ready); end
        repeat (70) @(negedge CLK);
        #1;
        checks++; if (dv_cnt !== dv || busy !== 1'b0) begin errors++; $display("FAIL mid_no_digest: digests %0d busy %b want 0/0", dv_cnt - dv, busy); end
        load_block(0, 7, 1'b0, 2);
        @(posedge CLK); #1;
        RST = 1'b1;
        msg_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        wbuf = 1'b0;
        rbuf = 1'b0;
        @(negedge CLK);
        checks++; if (wr_addr !== 4'd0 || Load_done !== 1'b0) begin errors++; $display("FAIL partial_reset: wr_addr %0d Load_done %b want 0/0", wr_addr, Load_done); end
        #1; ld = ld_cnt;
        load_block(0, 16, 1'b1, 2);
        hash_block(1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ld_cnt - ld !== 1) begin errors++; $display("FAIL partial_load_done_count: got %0d want 1", ld_cnt - ld); end
    endtask

    task automatic test_random;
        bit last;
        for (int n = 0; n < 4; n++) begin
            last = 1'($urandom_range(0, 1));
            load_block(0, 16, last, 2);
            hash_block(last, 1'b0, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_block();
        test_toggle_valid();
        test_two_block();
`ifdef MD5_PINGPONG_EN
        test_pingpong();
`else
        test_stall();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
